// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : Instruction fetch stage. Issues in-order, credit-limited
//            requests to instruction memory at sequential PCs, buffers the
//            returned words in a small FIFO and presents the head entry to
//            decode. A redirect flushes the buffer and arranges for the
//            responses still in flight to be discarded.
// Ports    : clk, rst_n            - clock, async active-low reset
//            IMEM_req_*            - request channel (valid/ready, address)
//            IMEM_rsp_*            - in-order response channel, no backpressure
//            DFO_*                 - {instr, pc, pc+4, valid} to decode
//            CFI_PC_stall          - decode holding the current head
//            CFI_PC_redirect/target- back-end redirect of the fetch stream
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
   parameter int                    W_AA_INSTR = 32,
   parameter int                    W_AD_INSTR = 32,
   parameter logic [W_AA_INSTR-1:0] RESET_VEC  = 32'h0000_0000,
   parameter int                    FIFO_DEPTH = 2,
   parameter logic [W_AD_INSTR-1:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic                  clk,
   input  logic                  rst_n,
   output logic                  IMEM_req_valid,
   output logic [W_AA_INSTR-1:0] IMEM_req_addr,
   input  logic                  IMEM_req_ready,
   input  logic                  IMEM_rsp_valid,
   input  logic [W_AD_INSTR-1:0] IMEM_rsp_data,
   output logic [W_AD_INSTR-1:0] DFO_AD_instr,
   output logic [W_AA_INSTR-1:0] DFO_AA_pc,
   output logic [W_AA_INSTR-1:0] DFO_AA_spec,
   output logic                  DFO_PV_instr,
   input  logic                  CFI_PC_stall,
   input  logic                  CFI_PC_redirect,
   input  logic [W_AA_INSTR-1:0] CFI_AA_target
);

   localparam int                    PW      = $clog2(FIFO_DEPTH);
   localparam int                    CW      = PW + 1;
   localparam logic [CW-1:0]         DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW:0]           DEPTH_S = (CW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0]         CNT_ONE = CW'(1);
   localparam logic [PW-1:0]         PTR_ONE = PW'(1);
   localparam logic [W_AA_INSTR-1:0] PC_STEP = W_AA_INSTR'(4);

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic [W_AA_INSTR-1:0] pc_q, pc_d;
   logic [CW-1:0]         out_cnt_q, out_cnt_d;     // requests accepted, not yet answered
   logic [CW-1:0]         drop_cnt_q, drop_cnt_d;   // stale responses still to discard
   logic [CW-1:0]         fifo_cnt_q, fifo_cnt_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         aq_rd_ptr_q, aq_rd_ptr_d;
   logic [PW-1:0]         aq_wr_ptr_q, aq_wr_ptr_d;
   logic [W_AD_INSTR-1:0] fifo_data_q [FIFO_DEPTH];
   logic [W_AD_INSTR-1:0] fifo_data_d [FIFO_DEPTH];
   logic [W_AA_INSTR-1:0] fifo_pc_q   [FIFO_DEPTH];
   logic [W_AA_INSTR-1:0] fifo_pc_d   [FIFO_DEPTH];
   // Address of every accepted request, in issue order; one entry is
   // retired per response (stale or not), so it always holds exactly
   // out_cnt_q entries and its head is the address of the next response.
   logic [W_AA_INSTR-1:0] aq_addr_q   [FIFO_DEPTH];
   logic [W_AA_INSTR-1:0] aq_addr_d   [FIFO_DEPTH];

   // ---------------------------------------------------------------------
   // Handshake decode
   // ---------------------------------------------------------------------
   logic [CW:0] credit_sum;
   logic        req_fire;
   logic        rsp_drop;
   logic        push;
   logic        pop;
   logic        head_valid;

   assign credit_sum     = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
   // rst_n gates the request so the port reads idle while reset is held.
   assign IMEM_req_valid = rst_n && !CFI_PC_redirect && (credit_sum < DEPTH_S);
   assign IMEM_req_addr  = pc_q;
   assign req_fire       = IMEM_req_valid && IMEM_req_ready;

   // A response landing in the redirect cycle belongs to the old stream.
   assign rsp_drop   = IMEM_rsp_valid && (CFI_PC_redirect || (drop_cnt_q != '0));
   assign push       = IMEM_rsp_valid && !rsp_drop;
   assign head_valid = (fifo_cnt_q != '0);
   assign pop        = head_valid && !CFI_PC_stall && !CFI_PC_redirect;

   // ---------------------------------------------------------------------
   // Decode-facing outputs, straight from the FIFO head registers
   // ---------------------------------------------------------------------
   assign DFO_PV_instr = head_valid;
   assign DFO_AD_instr = head_valid ? fifo_data_q[rd_ptr_q] : NOP_INSTR;
   assign DFO_AA_pc    = head_valid ? fifo_pc_q[rd_ptr_q] : '0;
   assign DFO_AA_spec  = head_valid ? (fifo_pc_q[rd_ptr_q] + PC_STEP) : '0;

   // Redirect targets are forced word-aligned, so the low bits are ignored.
   logic unused_tgt_lsbs;
   assign unused_tgt_lsbs = ^CFI_AA_target[1:0];

   // ---------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      pc_d        = pc_q;
      drop_cnt_d  = drop_cnt_q;
      fifo_cnt_d  = fifo_cnt_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      aq_rd_ptr_d = aq_rd_ptr_q;
      aq_wr_ptr_d = aq_wr_ptr_q;
      fifo_data_d = fifo_data_q;
      fifo_pc_d   = fifo_pc_q;
      aq_addr_d   = aq_addr_q;

      out_cnt_d = out_cnt_q + (req_fire ? CNT_ONE : '0)
                            - (IMEM_rsp_valid ? CNT_ONE : '0);

      if (req_fire) begin
         aq_addr_d[aq_wr_ptr_q] = pc_q;
         aq_wr_ptr_d            = aq_wr_ptr_q + PTR_ONE;
         pc_d                   = pc_q + PC_STEP;
      end

      if (IMEM_rsp_valid) begin
         aq_rd_ptr_d = aq_rd_ptr_q + PTR_ONE;
      end

      if (CFI_PC_redirect) begin
         // Every request still outstanding after this cycle is stale.
         pc_d       = {CFI_AA_target[W_AA_INSTR-1:2], 2'b00};
         drop_cnt_d = out_cnt_d;
         fifo_cnt_d = '0;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
      end else begin
         if (IMEM_rsp_valid && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - CNT_ONE;
         end
         if (push) begin
            fifo_data_d[wr_ptr_q] = IMEM_rsp_data;
            fifo_pc_d[wr_ptr_q]   = aq_addr_q[aq_rd_ptr_q];
            wr_ptr_d              = wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
         end
         case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_ONE;
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_ONE;
            default: fifo_cnt_d = fifo_cnt_q;
         endcase
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_VEC;
         out_cnt_q   <= '0;
         drop_cnt_q  <= '0;
         fifo_cnt_q  <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         aq_rd_ptr_q <= '0;
         aq_wr_ptr_q <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_data_q[i] <= '0;
            fifo_pc_q[i]   <= '0;
            aq_addr_q[i]   <= '0;
         end
      end else begin
         pc_q        <= pc_d;
         out_cnt_q   <= out_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
         fifo_cnt_q  <= fifo_cnt_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         aq_rd_ptr_q <= aq_rd_ptr_d;
         aq_wr_ptr_q <= aq_wr_ptr_d;
         fifo_data_q <= fifo_data_d;
         fifo_pc_q   <= fifo_pc_d;
         aq_addr_q   <= aq_addr_d;
      end
   end

   // ---------------------------------------------------------------------
   // Invariants
   // ---------------------------------------------------------------------
   a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (fifo_cnt_q == DEPTH_C)));
   a_no_spurious_rsp : assert property (@(posedge clk) disable iff (!rst_n)
      !(IMEM_rsp_valid && (out_cnt_q == '0)));
   a_out_cap : assert property (@(posedge clk) disable iff (!rst_n)
      out_cnt_q <= DEPTH_C);
   a_drop_cap : assert property (@(posedge clk) disable iff (!rst_n)
      drop_cnt_q <= out_cnt_q);
   a_addr_aligned : assert property (@(posedge clk) disable iff (!rst_n)
      IMEM_req_addr[1:0] == 2'b00);

endmodule
`default_nettype wire
